// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - handshake and status bundle for pipeline_sequencer
//
// Groups every non-clock/reset signal of the sequencer.
//   master : the pipeline datapath / hazard unit side (drives requests and next values)
//   slave  : the sequencer itself (drives registered boundaries, pc_en, state, counters)
// Signals:
//   in_valid, stage_d, ctrl_d                  next boundary contents
//   stall_req, flush_req, halt_req, resume     control requests
//   cnt_clr                                    synchronous counter clear
//   stage_q, ctrl_q, stage_valid               registered boundaries
//   pc_en, state                               PC enable and sequencer state
//   cycle_cnt, retire_cnt, stall_cnt, flush_cnt performance counters
interface pipeline_sequencer_if #(
  parameter int STAGES = 4,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 32
);
  logic                       in_valid;
  logic [STAGES*DATA_W-1:0]   stage_d;
  logic [STAGES*CTRL_W-1:0]   ctrl_d;
  logic                       stall_req;
  logic                       flush_req;
  logic                       halt_req;
  logic                       resume;
  logic                       cnt_clr;
  logic [STAGES*DATA_W-1:0]   stage_q;
  logic [STAGES*CTRL_W-1:0]   ctrl_q;
  logic [STAGES-1:0]          stage_valid;
  logic                       pc_en;
  logic [1:0]                 state;
  logic [CNT_W-1:0]           cycle_cnt;
  logic [CNT_W-1:0]           retire_cnt;
  logic [CNT_W-1:0]           stall_cnt;
  logic [CNT_W-1:0]           flush_cnt;

  modport master (
    output in_valid, stage_d, ctrl_d, stall_req, flush_req, halt_req, resume, cnt_clr,
    input  stage_q, ctrl_q, stage_valid, pc_en, state,
           cycle_cnt, retire_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, stage_d, ctrl_d, stall_req, flush_req, halt_req, resume, cnt_clr,
    output stage_q, ctrl_q, stage_valid, pc_en, state,
           cycle_cnt, retire_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - pipeline boundary register sequencer with stall/flush/halt
//
// Owns the STAGES boundary registers (0=IF/ID .. STAGES-1=MEM/WB), applies
// stall bubbles, flushes and halt/drain sequencing, and keeps performance counters.
// Ports:
//   clk   single clock, rising edge
//   rst_  asynchronous active-low reset; release is synchronised internally
//   bus   pipeline_sequencer_if.slave (requests in, boundaries/state/counters out)
module pipeline_sequencer #(
  parameter int STAGES      = 4,
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 8,
  parameter int STALL_POS   = 1,
  parameter int FLUSH_DEPTH = 3,
  parameter int HALT_POS    = 2,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_,
  pipeline_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } seqState_t;

  seqState_t                 stateQ, stateD;
  logic [1:0]                syncQ;
  logic                      upd;
  logic [STAGES-1:0]         validQ, validD, loadMask, bubbleMask;
  logic [STAGES*DATA_W-1:0]  dataQ;
  logic [STAGES*CTRL_W-1:0]  ctrlQ;
  logic                      inValidEff;
  logic                      pcEnD;
  logic                      stallApplied, flushApplied;
  logic [CNT_W-1:0]          cycleCnt, retireCnt, stallCnt, flushCnt;

  // Reset asserts asynchronously but releases through two flops, so no state
  // update happens until the release has been seen cleanly on two edges.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) syncQ <= 2'b00;
    else       syncQ <= {syncQ[0], 1'b1};
  end
  assign upd = syncQ[1];

  always_comb begin
    stateD       = stateQ;
    loadMask     = '0;
    bubbleMask   = '0;
    inValidEff   = 1'b0;
    pcEnD        = 1'b0;
    stallApplied = 1'b0;
    flushApplied = 1'b0;
    validD       = validQ;

    case (stateQ)
      RUN: begin
        inValidEff = bus.in_valid;
        loadMask   = '1;
        if (bus.halt_req) begin
          // The halt instruction itself and everything younger is squashed.
          for (int i = 0; i < STAGES; i++)
            if (i <= HALT_POS) bubbleMask[i] = 1'b1;
          stateD = DRAIN;
        end else if (bus.flush_req) begin
          for (int i = 0; i < STAGES; i++)
            if (i < FLUSH_DEPTH) bubbleMask[i] = 1'b1;
          pcEnD        = 1'b1;
          flushApplied = 1'b1;
        end else if (bus.stall_req) begin
          for (int i = 0; i < STAGES; i++)
            if (i < STALL_POS) loadMask[i] = 1'b0;
          bubbleMask[STALL_POS] = 1'b1;
          stallApplied          = 1'b1;
        end else begin
          pcEnD = 1'b1;
        end
      end
      DRAIN: begin
        loadMask = '1;
      end
      HALTED: begin
        if (bus.resume) stateD = RUN;
      end
      default: stateD = RUN;
    endcase

    for (int i = 0; i < STAGES; i++) begin
      if (loadMask[i])
        validD[i] = ((i == 0) ? inValidEff : validQ[(i == 0) ? 0 : i - 1]) & ~bubbleMask[i];
    end

    if (stateQ == DRAIN && validD == '0) stateD = HALTED;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      stateQ <= RUN;
      validQ <= '0;
      dataQ  <= '0;
      ctrlQ  <= '0;
    end else if (upd) begin
      stateQ <= stateD;
      validQ <= validD;
      for (int i = 0; i < STAGES; i++) begin
        if (loadMask[i]) begin
          dataQ[i*DATA_W +: DATA_W] <= bus.stage_d[i*DATA_W +: DATA_W];
          // Invalid boundaries always carry zero control so bubbles are inert.
          ctrlQ[i*CTRL_W +: CTRL_W] <= validD[i] ? bus.ctrl_d[i*CTRL_W +: CTRL_W] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cycleCnt  <= '0;
      retireCnt <= '0;
      stallCnt  <= '0;
      flushCnt  <= '0;
    end else if (upd) begin
      if (bus.cnt_clr) begin
        cycleCnt  <= '0;
        retireCnt <= '0;
        stallCnt  <= '0;
        flushCnt  <= '0;
      end else begin
        if (stateQ != HALTED)    cycleCnt  <= cycleCnt  + CNT_W'(1);
        if (validQ[STAGES-1])    retireCnt <= retireCnt + CNT_W'(1);
        if (stallApplied)        stallCnt  <= stallCnt  + CNT_W'(1);
        if (flushApplied)        flushCnt  <= flushCnt  + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en       = pcEnD & upd & rst_;
  assign bus.stage_q     = dataQ;
  assign bus.ctrl_q      = ctrlQ;
  assign bus.stage_valid = validQ;
  assign bus.state       = stateQ;
  assign bus.cycle_cnt   = cycleCnt;
  assign bus.retire_cnt  = retireCnt;
  assign bus.stall_cnt   = stallCnt;
  assign bus.flush_cnt   = flushCnt;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - scoreboard bench for pipeline_sequencer
module tb_pipeline_sequencer;
  localparam int ST = 4;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam logic [ST*CW-1:0] CPAT = 32'h44332211;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  pipeline_sequencer_if #(.STAGES(ST), .DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) bus();

  pipeline_sequencer #(
    .STAGES(ST), .DATA_W(DW), .CTRL_W(CW), .STALL_POS(1),
    .FLUSH_DEPTH(3), .HALT_POS(2), .CNT_W(NW)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      0: return 64'(bus.stage_valid);
      1: return 64'(bus.state);
      2: return 64'(bus.cycle_cnt);
      3: return 64'(bus.retire_cnt);
      4: return 64'(bus.stall_cnt);
      5: return 64'(bus.flush_cnt);
      6: return 64'(bus.ctrl_q);
      default: return 64'(bus.stage_q[DW-1:0]);
    endcase
  endfunction

  function automatic logic [63:0] ctrl_exp(input logic [ST-1:0] v);
    logic [ST*CW-1:0] p;
    logic [ST*CW-1:0] r;
    p = CPAT;
    r = '0;
    for (int i = 0; i < ST; i++)
      if (v[i]) r[i*CW +: CW] = p[i*CW +: CW];
    return 64'(r);
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_pipe(input string tag, input logic [ST-1:0] v);
    push_exp({tag, "_valid"}, 0, 64'(v));
    push_exp({tag, "_ctrl"}, 6, ctrl_exp(v));
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic pc_chk(input string tag, input logic exp);
    #1;
    check_val(tag, 64'(bus.pc_en), 64'(exp));
  endtask

  task automatic set_in(input logic iv, input logic stl, input logic fl,
                        input logic hl, input logic rs, input logic clr);
    bus.in_valid  = iv;
    bus.stall_req = stl;
    bus.flush_req = fl;
    bus.halt_req  = hl;
    bus.resume    = rs;
    bus.cnt_clr   = clr;
  endtask

  // Four fetch cycles fill any pipe state completely; counters cleared on the first.
  task automatic fill(input string tag);
    set_in(1, 0, 0, 0, 0, 1);
    cyc();
    bus.cnt_clr = 1'b0;
    cyc();
    cyc();
    push_pipe(tag, 4'b1111);
    cyc();
  endtask

  logic [ST-1:0] walk [10];

  initial begin
    walk = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111,
             4'b1110, 4'b1100, 4'b1000, 4'b0000};
    bus.ctrl_d  = CPAT;
    bus.stage_d = '0;
    set_in(0, 0, 0, 0, 0, 0);

    // Reset state
    #2 rst_ = 1'b0;
    #1;
    check_val("rst_valid", obs(0), 64'h0);
    check_val("rst_state", obs(1), 64'h0);
    check_val("rst_cycle", obs(2), 64'h0);
    check_val("rst_ctrl",  obs(6), 64'h0);
    check_val("rst_pc_en", 64'(bus.pc_en), 64'h0);
    #19 rst_ = 1'b1;
    cyc();
    cyc();
    check_val("post_rst_state", obs(1), 64'h0);

    // Fill and drain walk
    set_in(0, 0, 0, 0, 0, 1);
    push_exp("clr_cycle", 2, 64'h0);
    cyc();
    for (int k = 0; k < 10; k++) begin
      set_in((k < 6), 0, 0, 0, 0, 0);
      bus.stage_d = {$urandom(), $urandom(), $urandom(), $urandom()};
      push_pipe($sformatf("walk%0d", k), walk[k]);
      cyc();
    end
    check_val("walk_retire", obs(3), 64'd6);
    check_val("walk_cycle",  obs(2), 64'd10);

    // Single-cycle stall on a full pipe
    bus.stage_d[DW-1:0] = 32'hAAAA_0001;
    fill("stall_fill");
    set_in(1, 1, 0, 0, 0, 0);
    bus.stage_d[DW-1:0] = 32'hBBBB_0002;
    pc_chk("stall_pc_en", 1'b0);
    push_pipe("stall", 4'b1101);
    push_exp("stall_hold0", 7, 64'h0000_0000_AAAA_0001);
    push_exp("stall_cnt", 4, 64'd1);
    push_exp("stall_fcnt", 5, 64'd0);
    cyc();
    set_in(1, 0, 0, 0, 0, 0);
    push_exp("stall_resume0", 7, 64'h0000_0000_BBBB_0002);
    cyc();

    // Stall and flush together: flush wins
    fill("sf_fill");
    set_in(1, 1, 1, 0, 0, 0);
    pc_chk("sf_pc_en", 1'b1);
    push_pipe("sf", 4'b1000);
    push_exp("sf_stall_cnt", 4, 64'd0);
    push_exp("sf_flush_cnt", 5, 64'd1);
    cyc();

    // Halt, drain, halted, resume
    fill("halt_fill");
    set_in(1, 0, 0, 1, 0, 1);
    pc_chk("halt_pc_en", 1'b0);
    push_exp("halt_state", 1, 64'd1);
    push_pipe("halt", 4'b1000);
    push_exp("halt_retire", 3, 64'd0);
    cyc();
    set_in(1, 1, 1, 1, 1, 0);
    pc_chk("drain_pc_en", 1'b0);
    push_exp("drain_state", 1, 64'd2);
    push_pipe("drain", 4'b0000);
    push_exp("drain_retire", 3, 64'd1);
    push_exp("drain_cycle", 2, 64'd1);
    push_exp("drain_flush", 5, 64'd0);
    push_exp("drain_stall", 4, 64'd0);
    cyc();
    set_in(1, 1, 1, 1, 0, 0);
    pc_chk("hlt_pc_en", 1'b0);
    push_exp("hlt_state", 1, 64'd2);
    push_exp("hlt_valid", 0, 64'd0);
    push_exp("hlt_cycle", 2, 64'd1);
    push_exp("hlt_retire", 3, 64'd1);
    push_exp("hlt_flush", 5, 64'd0);
    push_exp("hlt_stall", 4, 64'd0);
    cyc();
    set_in(0, 0, 0, 0, 1, 0);
    pc_chk("resume_pc_en_pre", 1'b0);
    push_exp("resume_state", 1, 64'd0);
    cyc();
    set_in(0, 0, 0, 0, 0, 0);
    pc_chk("run_pc_en", 1'b1);
    push_exp("run_cycle", 2, 64'd2);
    cyc();

    // Reset in the middle of a drain
    fill("rd_fill");
    set_in(1, 0, 0, 1, 0, 0);
    push_exp("rd_state", 1, 64'd1);
    cyc();
    set_in(0, 0, 0, 0, 0, 0);
    #2 rst_ = 1'b0;
    #1;
    check_val("rd_valid", obs(0), 64'h0);
    check_val("rd_state0", obs(1), 64'h0);
    check_val("rd_ctrl", obs(6), 64'h0);
    check_val("rd_data", obs(7), 64'h0);
    check_val("rd_retire", obs(3), 64'h0);
    check_val("rd_pc_en", 64'(bus.pc_en), 64'h0);
    #3 rst_ = 1'b1;
    cyc();
    check_val("rd_rel_state", obs(1), 64'h0);
    check_val("rd_rel_cycle", obs(2), 64'h0);
    check_val("rd_rel_valid", obs(0), 64'h0);
    cyc();

    // Counter wrap and clear-at-max
    set_in(0, 0, 0, 0, 0, 1);
    push_exp("wrap_clr", 2, 64'd0);
    cyc();
    bus.cnt_clr = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) push_exp("wrap_max", 2, 64'd15);
      cyc();
    end
    push_exp("wrap_zero", 2, 64'd0);
    cyc();
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) push_exp("wrap_max2", 2, 64'd15);
      cyc();
    end
    bus.cnt_clr = 1'b1;
    push_exp("clr_at_max", 2, 64'd0);
    cyc();
    bus.cnt_clr = 1'b0;
    push_exp("after_clr", 2, 64'd1);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter STAGES, 4, number of pipeline boundary registers (0=IF/ID ... STAGES-1=MEM/WB); legal range 2..8.
REQ-002 Parameter DATA_W, 32, datapath bits per boundary.
REQ-003 Parameter CTRL_W, 8, control bits per boundary.
REQ-004 Parameter STALL_POS, 1, boundary that receives the bubble on a stall; range 1..STAGES-1.
REQ-005 Parameter FLUSH_DEPTH, 3, number of youngest boundaries cleared on a flush; range 1..STAGES.
REQ-006 Parameter HALT_POS, 2, boundary at which a halt is detected; range 0..STAGES-1.
REQ-007 Parameter CNT_W, 32, width of each performance counter.
REQ-008 clk  in  1  single clock; all state updates on rising edge.
REQ-009 rst_  in  1  reset, asynchronous, active-low.
REQ-010 in_valid  in  1  fetch stage presents a valid instruction.
REQ-011 stage_d  in  STAGES*DATA_W  next datapath value per boundary; slice i feeds boundary i.
REQ-012 ctrl_d  in  STAGES*CTRL_W  next control value per boundary; slice i feeds boundary i.
REQ-013 stall_req  in  1  load-use stall from hazard detection.
REQ-014 flush_req  in  1  taken branch or jump resolved.
REQ-015 halt_req  in  1  instruction in boundary HALT_POS is a halt.
REQ-016 resume  in  1  restart from HALTED.
REQ-017 cnt_clr  in  1  synchronous clear of all counters.
REQ-018 stage_q  out  STAGES*DATA_W  registered datapath per boundary.
REQ-019 ctrl_q  out  STAGES*CTRL_W  registered control per boundary; all zero whenever that boundary is invalid.
REQ-020 stage_valid  out  STAGES  valid bit per boundary.
REQ-021 pc_en  out  1  PC update enable (combinational from state and requests).
REQ-022 state  out  2  00=RUN, 01=DRAIN, 10=HALTED.
REQ-023 cycle_cnt, retire_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-024 Normal advance in RUN: boundary 0 loads in_valid, stage_d[0], ctrl_d[0]; boundary i>0 loads valid_q[i-1], stage_d[i], ctrl_d[i]; one boundary per cycle.
REQ-025 Any boundary loading valid=0 SHALL load ctrl=0; data still loads stage_d.
REQ-026 Request priority in RUN: halt_req > flush_req > stall_req.
REQ-027 Stall: boundaries 0..STALL_POS-1 hold all state; boundary STALL_POS loads a bubble (valid=0, ctrl=0); higher boundaries advance; pc_en=0.
REQ-028 Flush: boundaries 0..FLUSH_DEPTH-1 load valid=0, ctrl=0; higher boundaries advance; pc_en=1; a simultaneous stall_req is ignored.
REQ-029 Halt in RUN: boundaries 0..HALT_POS load valid=0, ctrl=0 (the halt does not retire); higher boundaries advance; pc_en=0; next state DRAIN.
REQ-030 DRAIN: in_valid is treated as 0; all boundaries advance; pc_en=0; stall_req, flush_req, halt_req and resume are ignored.
REQ-031 DRAIN to HALTED on the edge after which all stage_valid bits are 0.
REQ-032 HALTED: all boundaries hold; pc_en=0; all requests except resume are ignored.
REQ-033 HALTED to RUN on the edge where resume=1; pc_en=1 from the first RUN cycle.
REQ-034 pc_en=1 in RUN when neither stall_req nor halt_req is asserted.
REQ-035 cycle_cnt increments every cycle in RUN or DRAIN and holds in HALTED.
REQ-036 retire_cnt increments when stage_valid[STAGES-1]=1, in any state.
REQ-037 stall_cnt increments on each applied stall; flush_cnt increments on each applied flush; requests that are ignored or overridden are not counted.
REQ-038 All counters wrap modulo 2^CNT_W; cnt_clr zeroes all counters and overrides increments in the same cycle.

Reset
REQ-039 rst_ low SHALL immediately set all stage_valid, ctrl_q, stage_q and counters to 0 and state to RUN.
REQ-040 pc_en SHALL be 0 while rst_ is low.
REQ-041 Reset asserted in any state, including mid-DRAIN, SHALL abort the operation; after release, the block is in RUN with the pipeline empty.
REQ-042 Reset release is synchronised to clk before the first state update.

Verification
REQ-043 Defaults, in_valid=1 for 6 cycles, then 0 -> stage_valid walks 0001, 0011, 0111, 1111; retire_cnt=6 after drain; cycle_cnt=cycle count.
REQ-044 Full pipe, stall_req pulse of 1 cycle -> boundary 0 held, stage_valid[1]=0 next cycle, pc_en=0 that cycle, stall_cnt=1.
REQ-045 stall_req and flush_req asserted together -> flush applied, stage_valid=1000, stall_cnt=0, flush_cnt=1, pc_en=1.
REQ-046 Full pipe, halt_req -> state DRAIN, stage_valid=1000 then 0000, state HALTED; retire_cnt +1 only; resume -> RUN and pc_en=1.
REQ-047 rst_ low mid-DRAIN -> outputs 0 immediately; after release, state=00 and counters=0.
REQ-048 cnt_clr together with an increment condition at counter value 2^CNT_W-1 -> counter=0; without cnt_clr, the counter wraps to 0.
